// File: rtl/imm_ext_pipe.sv
// Registered immediate extender for the decode path: one instruction word per
// handshake, sign-extended immediate one cycle later, 2-entry skid, error counter.
module imm_ext_pipe #(
  parameter int XLEN     = 32,
  parameter int AUTO_SEL = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic             imm_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             cnt_clr
);

  localparam logic [2:0] F_I = 3'd0;
  localparam logic [2:0] F_S = 3'd1;
  localparam logic [2:0] F_B = 3'd2;
  localparam logic [2:0] F_U = 3'd3;
  localparam logic [2:0] F_J = 3'd4;
  localparam logic [2:0] F_X = 3'd7;

  function automatic logic [2:0] auto_fmt(input logic [6:0] op);
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: auto_fmt = F_I;
      7'b0100011:                                     auto_fmt = F_S;
      7'b1100011:                                     auto_fmt = F_B;
      7'b0110111, 7'b0010111:                         auto_fmt = F_U;
      7'b1101111:                                     auto_fmt = F_J;
      default:                                        auto_fmt = F_X;
    endcase
  endfunction

  // Build a 32-bit signed immediate, then sign-extend it to XLEN (U included).
  function automatic logic signed [XLEN-1:0] ext_imm(input logic [31:0] ins,
                                                     input logic [2:0]  fmt);
    logic signed [31:0] raw;
    raw = '0;
    case (fmt)
      F_I: raw = {{20{ins[31]}}, ins[31:20]};
      F_S: raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      F_B: raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      F_U: raw = {ins[31:12], 12'b0};
      F_J: raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: raw = '0;
    endcase
    ext_imm = XLEN'(raw);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + 1'b1;
  endfunction

  logic [2:0]              fmt_p0;
  logic                    err_p0;
  logic signed [XLEN-1:0]  imm_p0;
  logic                    acc_p0;

  logic                    vld_p1;
  logic signed [XLEN-1:0]  imm_p1;
  logic                    err_p1;

  logic                    skid_vld;
  logic signed [XLEN-1:0]  skid_imm;
  logic                    skid_err;

  logic [CNT_W-1:0]        cnt;

  // Stage p0: decode and extend the incoming word
  assign fmt_p0   = (AUTO_SEL != 0) ? auto_fmt(instr[6:0]) : imm_sel;
  assign err_p0   = (fmt_p0 > F_J);
  assign imm_p0   = ext_imm(instr, fmt_p0);
  assign in_ready = !skid_vld;
  assign acc_p0   = in_valid && in_ready;

  // Stage p1: output register, refilled from skid first to keep FIFO order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      imm_p1   <= '0;
      err_p1   <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      if (!vld_p1 || out_ready) begin
        if (skid_vld) begin
          vld_p1   <= 1'b1;
          imm_p1   <= skid_imm;
          err_p1   <= skid_err;
          skid_vld <= 1'b0;
        end else begin
          vld_p1 <= acc_p0;
          if (acc_p0) begin
            imm_p1 <= imm_p0;
            err_p1 <= err_p0;
          end
        end
      end else if (acc_p0) begin
        skid_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc_p0 && vld_p1 && !out_ready) begin
      skid_imm <= imm_p0;
      skid_err <= err_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (acc_p0 && err_p0) begin
      cnt <= sat_inc(cnt);
    end
  end

  assign out_valid = vld_p1;
  assign imm_out   = imm_p1;
  assign imm_err   = err_p1;
  assign err_count = cnt;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: four configurations driven by one shared
// stimulus stream (RV32, RV64, auto-select, 2-bit counter).
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  imm_sel = '0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;

  logic        ir32, ov32, er32;
  logic [31:0] im32;
  logic [15:0] ec32;
  logic        ir64, ov64, er64;
  logic [63:0] im64;
  logic [15:0] ec64;
  logic        ira, ova, era;
  logic [31:0] ima;
  logic [15:0] eca;
  logic        irs, ovs, ers;
  logic [31:0] ims;
  logic [1:0]  ecs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .AUTO_SEL(0), .CNT_W(16)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32), .instr(instr),
    .imm_sel(imm_sel), .out_valid(ov32), .out_ready(out_ready), .imm_out(im32),
    .imm_err(er32), .err_count(ec32), .cnt_clr(cnt_clr));

  imm_ext_pipe #(.XLEN(64), .AUTO_SEL(0), .CNT_W(16)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64), .instr(instr),
    .imm_sel(imm_sel), .out_valid(ov64), .out_ready(out_ready), .imm_out(im64),
    .imm_err(er64), .err_count(ec64), .cnt_clr(cnt_clr));

  imm_ext_pipe #(.XLEN(32), .AUTO_SEL(1), .CNT_W(16)) uauto (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ira), .instr(instr),
    .imm_sel(imm_sel), .out_valid(ova), .out_ready(out_ready), .imm_out(ima),
    .imm_err(era), .err_count(eca), .cnt_clr(cnt_clr));

  imm_ext_pipe #(.XLEN(32), .AUTO_SEL(0), .CNT_W(2)) usat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irs), .instr(instr),
    .imm_sel(imm_sel), .out_valid(ovs), .out_ready(out_ready), .imm_out(ims),
    .imm_err(ers), .err_count(ecs), .cnt_clr(cnt_clr));

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [63:0] exp;
    logic        err;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [2:0] s);
    @(negedge clk);
    instr    = ins;
    imm_sel  = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic clr_cnt();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vt[1] = '{32'hFE112E23, 3'd1, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vt[2] = '{32'hFE000CE3, 3'd2, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    vt[3] = '{32'h123450B7, 3'd3, 64'h0000000012345000, 1'b0};
    vt[4] = '{32'h008000EF, 3'd4, 64'h0000000000000008, 1'b0};
    vt[5] = '{32'h800000B7, 3'd3, 64'hFFFFFFFF80000000, 1'b0};
    vt[6] = '{32'h7FF00093, 3'd0, 64'h00000000000007FF, 1'b0};
    vt[7] = '{32'h12345678, 3'd5, 64'h0, 1'b1};
    vt[8] = '{32'h00B50533, 3'd7, 64'h0, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {63'b0, ov32}, 64'd0);
    chk("rst_imm_out", im64, 64'd0);
    chk("rst_imm_err", {63'b0, er32}, 64'd0);
    chk("rst_err_count", {48'b0, ec32}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {63'b0, ir32}, 64'd1);

    // table vectors
    for (int i = 0; i < 9; i++) begin
      send(vt[i].instr, vt[i].sel);
      chk($sformatf("v%0d_valid", i), {63'b0, ov32}, 64'd1);
      chk($sformatf("v%0d_imm32", i), {32'b0, im32}, {32'b0, vt[i].exp[31:0]});
      chk($sformatf("v%0d_err32", i), {63'b0, er32}, {63'b0, vt[i].err});
      chk($sformatf("v%0d_imm64", i), im64, vt[i].exp);
      chk($sformatf("v%0d_immauto", i), {32'b0, ima}, {32'b0, vt[i].exp[31:0]});
      chk($sformatf("v%0d_errauto", i), {63'b0, era}, {63'b0, vt[i].err});
    end
    @(negedge clk);
    chk("table_drained", {63'b0, ov32}, 64'd0);
    chk("table_cnt32", {48'b0, ec32}, 64'd2);
    chk("table_cntauto", {48'b0, eca}, 64'd2);
    clr_cnt();
    chk("clr_cnt32", {48'b0, ec32}, 64'd0);

    // auto-select ignores imm_sel
    send(32'hFE000CE3, 3'd7);
    chk("auto_b_imm", {32'b0, ima}, 64'hFFFFFFF8);
    chk("auto_b_err", {63'b0, era}, 64'd0);
    chk("manual_sel7_err", {63'b0, er32}, 64'd1);
    chk("manual_sel7_imm", {32'b0, im32}, 64'd0);
    send(32'h00B50533, 3'd0);
    chk("auto_illegal_err", {63'b0, era}, 64'd1);
    chk("auto_illegal_imm", {32'b0, ima}, 64'd0);
    chk("manual_i_imm", {32'b0, im32}, 64'd11);
    chk("auto_cnt", {48'b0, eca}, 64'd1);
    chk("manual_cnt", {48'b0, ec32}, 64'd1);
    clr_cnt();

    // saturation, then clear beating a same-cycle increment
    for (int i = 0; i < 5; i++) send(32'h00000033, 3'd5);
    chk("sat_cnt2", {62'b0, ecs}, 64'd3);
    chk("sat_cnt16", {48'b0, ec32}, 64'd5);
    @(negedge clk);
    instr = 32'h00000033; imm_sel = 3'd5; in_valid = 1'b1; cnt_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; cnt_clr = 1'b0;
    chk("clr_pri_cnt2", {62'b0, ecs}, 64'd0);
    chk("clr_pri_cnt16", {48'b0, ec32}, 64'd0);
    chk("clr_pri_word_err", {63'b0, er32}, 64'd1);

    // backpressure: output + skid hold two words, third waits
    @(negedge clk);
    out_ready = 1'b0; imm_sel = 3'd0; instr = 32'h00100093; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_w0_out", {32'b0, im32}, 64'd1);
    chk("bp_ready1", {63'b0, ir32}, 64'd1);
    instr = 32'h00200093;
    @(negedge clk);
    chk("bp_skid_full", {63'b0, ir32}, 64'd0);
    chk("bp_hold_a", {32'b0, im32}, 64'd1);
    instr = 32'h00300093;
    @(negedge clk);
    chk("bp_still_full", {63'b0, ir32}, 64'd0);
    chk("bp_hold_b", {32'b0, im32}, 64'd1);
    chk("bp_hold_valid", {63'b0, ov32}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_w1_out", {32'b0, im32}, 64'd2);
    chk("bp_ready_back", {63'b0, ir32}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_w2_out", {32'b0, im32}, 64'd3);
    chk("bp_w2_valid", {63'b0, ov32}, 64'd1);
    @(negedge clk);
    chk("bp_empty", {63'b0, ov32}, 64'd0);

    // reset mid-stream with skid full
    @(negedge clk);
    out_ready = 1'b0; imm_sel = 3'd0; instr = 32'h00100093; in_valid = 1'b1;
    @(negedge clk);
    imm_sel = 3'd5; instr = 32'h00000033;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mr_skid_full", {63'b0, ir32}, 64'd0);
    chk("mr_cnt_pre", {48'b0, ec32}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_out_valid", {63'b0, ov32}, 64'd0);
    chk("mr_cnt", {48'b0, ec32}, 64'd0);
    chk("mr_out_valid64", {63'b0, ov64}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("mr_no_stale", {63'b0, ov32}, 64'd0);
    chk("mr_in_ready", {63'b0, ir32}, 64'd1);
    send(32'h00500093, 3'd0);
    chk("mr_new_valid", {63'b0, ov32}, 64'd1);
    chk("mr_new_imm", {32'b0, im32}, 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
